// File: rtl/pattern_source_avst.sv
// pattern_source_avst
//
// Avalon-ST test-pattern source. It emits framed packets (startofpacket /
// endofpacket) and rotates round-robin over NUM_CHANNELS logical channels.
// The length, pattern and inter-packet gap of each packet are latched when the
// packet starts. Changes to those inputs take effect only at the next packet
// start.
//
// Handshake: a beat transfers on any clock edge where valid && ready
// (readyLatency 0). While valid is high and ready is low, data, channel,
// startofpacket and endofpacket hold their values. Every output is a register.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   enable          1 = keep generating packets; 0 = stop after the current one
//   mode            0/3 per-channel counter, 1 walking one, 2 channel-tagged index
//   pkt_len         beats per packet (0 behaves as 1)
//   idle_gap        cycles with valid low between packets
//   ready           sink ready
//   valid, data, channel, startofpacket, endofpacket   Avalon-ST source side
//   pkt_count       packets completed since reset (wraps at 2^32)
module pattern_source_avst #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int LEN_WIDTH    = 16,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [7:0]            idle_gap,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CH_W-1:0]       channel,
  output logic                  startofpacket,
  output logic                  endofpacket,
  output logic [31:0]           pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] LOW_MASK = {DATA_WIDTH{1'b1}} >> 8;

  state_t                state;
  logic [1:0]            mode_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat;
  logic [7:0]            gap_q;
  logic [7:0]            gap_cnt;
  logic [DATA_WIDTH-1:0] cnt [NUM_CHANNELS];

  // Payload for beat b of a packet on channel c. cv is the counter value
  // that the channel will have when this beat is presented.
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [1:0]            m,
    input logic [LEN_WIDTH-1:0]  b,
    input logic [CH_W-1:0]       c,
    input logic [DATA_WIDTH-1:0] cv
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (m)
      2'd1:    r = ONE << (32'(b) % DATA_WIDTH);
      2'd2:    r = (DATA_WIDTH'(8'(c)) << (DATA_WIDTH - 8)) | (DATA_WIDTH'(b) & LOW_MASK);
      default: r = cv;
    endcase
    return r;
  endfunction

  logic                  accept;
  logic                  last_accept;
  logic                  start_now;
  logic [CH_W-1:0]       ch_next;
  logic [CH_W-1:0]       start_ch;
  logic [DATA_WIDTH-1:0] cnt_inc;
  logic [DATA_WIDTH-1:0] start_cv;
  logic [LEN_WIDTH-1:0]  beat_next;
  logic                  eop_next;
  logic [LEN_WIDTH-1:0]  len_eff;

  always_comb begin
    accept      = valid && ready;
    last_accept = (state == S_SEND) && accept && endofpacket;
    ch_next     = (channel == CH_W'(NUM_CHANNELS - 1)) ? '0 : channel + 1'b1;
    cnt_inc     = cnt[channel] + 1'b1;
    beat_next   = beat + 1'b1;
    // The next beat is the last one when beat + 2 == length.
    eop_next    = (({1'b0, beat} + (LEN_WIDTH + 1)'(2)) == {1'b0, len_q});
    len_eff     = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
    // In IDLE/GAP the channel register already holds the next channel.
    // Coming straight out of SEND, the new packet uses the channel after
    // the one that just finished.
    start_ch    = (state == S_SEND) ? ch_next : channel;
    // With a single channel the packet just finished and the new one share
    // a counter. The new first beat must then see the post-increment value.
    start_cv    = (accept && (start_ch == channel)) ? cnt_inc : cnt[start_ch];
    start_now   = enable && ((state == S_IDLE) ||
                             (last_accept && (gap_q == 8'd0)) ||
                             ((state == S_GAP) && (gap_cnt == 8'd1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      valid         <= 1'b0;
      data          <= '0;
      channel       <= '0;
      startofpacket <= 1'b0;
      endofpacket   <= 1'b0;
      pkt_count     <= '0;
      mode_q        <= '0;
      len_q         <= '0;
      beat          <= '0;
      gap_q         <= '0;
      gap_cnt       <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) cnt[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          valid <= 1'b0;
        end
        S_SEND: begin
          if (accept) begin
            cnt[channel] <= cnt_inc;
            if (endofpacket) begin
              pkt_count     <= pkt_count + 32'd1;
              channel       <= ch_next;
              valid         <= 1'b0;
              startofpacket <= 1'b0;
              endofpacket   <= 1'b0;
              if (gap_q != 8'd0) begin
                state   <= S_GAP;
                gap_cnt <= gap_q;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              beat          <= beat_next;
              startofpacket <= 1'b0;
              endofpacket   <= eop_next;
              data          <= pattern(mode_q, beat_next, channel, cnt_inc);
            end
          end
        end
        S_GAP: begin
          // gap_cnt counts the low-valid cycles still to come, this one included.
          if (gap_cnt == 8'd1) state <= S_IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= S_IDLE;
      endcase

      // Every packet start goes through here. The assignments below take
      // priority over the IDLE/GAP/end-of-packet moves made above.
      if (start_now) begin
        state         <= S_SEND;
        mode_q        <= mode;
        len_q         <= len_eff;
        gap_q         <= idle_gap;
        beat          <= '0;
        valid         <= 1'b1;
        startofpacket <= 1'b1;
        endofpacket   <= (len_eff == LEN_WIDTH'(1));
        channel       <= start_ch;
        data          <= pattern(mode, LEN_WIDTH'(0), start_ch, start_cv);
      end
    end
  end

endmodule

// File: tb/tb_pattern_source_avst.sv
// Bench for pattern_source_avst (DATA_WIDTH 32, 4 channels, 16-bit length).
// A reference model turns each planned packet into a queue of expected beats.
// One negedge process checks every accepted beat against that queue, checks
// that the outputs hold while the sink stalls, and tracks pkt_count. Directed
// tests add hand-computed literal checks.
module tb_pattern_source_avst;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int LW = 16;
  localparam int CW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          enable   = 1'b0;
  logic [1:0]    mode     = 2'd0;
  logic [LW-1:0] pkt_len  = '0;
  logic [7:0]    idle_gap = '0;
  logic          ready    = 1'b1;
  logic          valid;
  logic [DW-1:0] data;
  logic [CW-1:0] channel;
  logic          sop;
  logic          eop;
  logic [31:0]   pkt_count;

  pattern_source_avst #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(NC),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .pkt_len      (pkt_len),
    .idle_gap     (idle_gap),
    .ready        (ready),
    .valid        (valid),
    .data         (data),
    .channel      (channel),
    .startofpacket(sop),
    .endofpacket  (eop),
    .pkt_count    (pkt_count)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          s;
    logic          e;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // model state
  logic [DW-1:0] m_cnt [NC];
  int m_ch = 0;

  // observation state
  int cyc = 0;
  int acc_pkts = 0;
  int seen_sops = 0;
  logic stall_prev = 1'b0;
  beat_t held;
  beat_t e_beat;
  logic [DW-1:0] acc_data_q[$];
  logic [CW-1:0] acc_ch_q[$];
  int sop_cyc_q[$];
  int eop_cyc_q[$];
  int rpat[6] = '{1, 0, 0, 1, 0, 1};
  logic use_pat = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // reference model: expected beats of one packet on the next channel
  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cnt[i] = '0;
    m_ch = 0;
    exp_q.delete();
  endtask

  task automatic model_packet(input int md, input int len);
    int l;
    beat_t bt;
    logic [DW-1:0] d;
    l = (len == 0) ? 1 : len;
    for (int b = 0; b < l; b++) begin
      case (md)
        1:       d = 32'h1 << (b % DW);
        2:       d = (DW'(m_ch) << 24) | (DW'(b) & 32'h00FF_FFFF);
        default: d = m_cnt[m_ch];
      endcase
      m_cnt[m_ch] = m_cnt[m_ch] + 1;
      bt.d = d;
      bt.c = CW'(m_ch);
      bt.s = (b == 0);
      bt.e = (b == l - 1);
      exp_q.push_back(bt);
    end
    m_ch = (m_ch + 1) % NC;
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
      acc_pkts   = 0;
      seen_sops  = 0;
    end else begin
      check("pkt_count", pkt_count, acc_pkts);
      if (stall_prev) check("hold", {valid, data, channel, sop, eop}, {1'b1, held});
      if (valid && sop && !stall_prev) begin
        seen_sops++;
        sop_cyc_q.push_back(cyc);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got data 0x%0h ch %0d with no beat expected (cycle %0d)",
                   data, channel, cyc);
        end else begin
          e_beat = exp_q.pop_front();
          check("beat_data", data, e_beat.d);
          check("beat_channel", channel, e_beat.c);
          check("beat_sop", sop, e_beat.s);
          check("beat_eop", eop, e_beat.e);
        end
        acc_data_q.push_back(data);
        acc_ch_q.push_back(channel);
        if (eop) begin
          acc_pkts++;
          eop_cyc_q.push_back(cyc);
        end
      end
      stall_prev = valid && !ready;
      held = {data, channel, sop, eop};
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    ready = 1'b1;
    use_pat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    acc_data_q.delete();
    acc_ch_q.delete();
    sop_cyc_q.delete();
    eop_cyc_q.delete();
    @(negedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_channel", channel, 0);
    check("rst_sop", sop, 0);
    check("rst_eop", eop, 0);
    check("rst_pkt_count", pkt_count, 0);
  endtask

  // Drops enable once drop_sops packets have been presented.
  // Returns once done_pkts packets have been accepted or the budget runs out.
  task automatic run_test(input int drop_sops, input int done_pkts, input int budget);
    int ri;
    bit done;
    ri = 0;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(posedge clk);
      #1;
      if (use_pat) ready = (rpat[ri % 6] != 0);
      ri++;
      @(negedge clk);
      #1;
      if (seen_sops >= drop_sops) enable = 1'b0;
      if (acc_pkts >= done_pkts) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL run_timeout: packets %0d required %0d", acc_pkts, done_pkts);
    end
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drained", exp_q.size(), 0);
    check("idle_after", valid, 0);
  endtask

  int exp_ch[5] = '{0, 1, 2, 3, 0};
  int lim;

  initial begin
    // 1: continuous streaming, counter pattern
    do_reset();
    mode = 2'd0; pkt_len = 16'd4; idle_gap = 8'd0;
    for (int k = 0; k < 5; k++) model_packet(0, 4);
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(negedge clk);
    #1;
    check("t1_latency_low", valid, 0);
    @(negedge clk);
    #1;
    check("t1_first_valid", valid, 1);
    check("t1_first_sop", sop, 1);
    run_test(5, 5, 200);
    check("t1_pkt_count", pkt_count, 5);
    check("t1_ch1_first", acc_ch_q[4], 1);
    check("t1_ch1_data0", acc_data_q[4], 0);
    check("t1_ch0_resume_ch", acc_ch_q[16], 0);
    check("t1_ch0_resume_b0", acc_data_q[16], 4);
    check("t1_ch0_resume_b3", acc_data_q[19], 7);
    for (int k = 0; k < 4; k++) check("t1_no_gap", sop_cyc_q[k + 1] - eop_cyc_q[k], 1);

    // 2: backpressure
    do_reset();
    pkt_len = 16'd3;
    for (int k = 0; k < 4; k++) model_packet(0, 3);
    use_pat = 1'b1;
    enable = 1'b1;
    run_test(4, 4, 300);
    check("t2_beats", acc_data_q.size(), 12);
    check("t2_b0", acc_data_q[0], 0);
    check("t2_b1", acc_data_q[1], 1);
    check("t2_b2", acc_data_q[2], 2);
    check("t2_ch1_b2", acc_data_q[5], 2);

    // 3: zero length and single-beat packets
    do_reset();
    pkt_len = 16'd0;
    for (int k = 0; k < 5; k++) model_packet(0, 0);
    enable = 1'b1;
    run_test(5, 5, 100);
    for (int k = 0; k < 5; k++) check("t3_ch_seq", acc_ch_q[k], exp_ch[k]);
    check("t3_ch0_second", acc_data_q[4], 1);
    check("t3_pkt_count", pkt_count, 5);
    pkt_len = 16'd1;
    for (int k = 0; k < 3; k++) model_packet(0, 1);
    enable = 1'b1;
    run_test(8, 8, 100);
    check("t3_len1_ch", acc_ch_q[5], 1);
    check("t3_len1_data", acc_data_q[5], 1);
    check("t3_pkt_count_8", pkt_count, 8);

    // 4: idle gap of 3
    do_reset();
    pkt_len = 16'd2; idle_gap = 8'd3;
    for (int k = 0; k < 4; k++) model_packet(0, 2);
    enable = 1'b1;
    run_test(4, 4, 200);
    for (int k = 0; k < 3; k++) check("t4_gap", sop_cyc_q[k + 1] - eop_cyc_q[k], 4);

    // 5: walking one, then channel tagged
    do_reset();
    idle_gap = 8'd0; mode = 2'd1; pkt_len = 16'd34;
    model_packet(1, 34);
    enable = 1'b1;
    run_test(1, 1, 200);
    check("t5_w0", acc_data_q[0], 32'h1);
    check("t5_w1", acc_data_q[1], 32'h2);
    check("t5_w31", acc_data_q[31], 32'h8000_0000);
    check("t5_w32", acc_data_q[32], 32'h1);
    check("t5_w33", acc_data_q[33], 32'h2);
    mode = 2'd2; pkt_len = 16'd6;
    for (int k = 0; k < 3; k++) model_packet(2, 6);
    enable = 1'b1;
    run_test(4, 4, 200);
    check("t5_tag_ch", acc_ch_q[46], 3);
    check("t5_tag_b5", acc_data_q[51], 32'h0300_0005);

    // 6a: enable dropped during beat 1
    do_reset();
    mode = 2'd0; pkt_len = 16'd4;
    model_packet(0, 4);
    enable = 1'b1;
    lim = 0;
    while (!(valid && !sop) && lim < 20) begin
      @(negedge clk);
      #1;
      lim++;
    end
    check("t6_beat1_seen", valid && !sop, 1);
    enable = 1'b0;
    lim = 0;
    while (acc_pkts < 1 && lim < 20) begin
      @(negedge clk);
      #1;
      lim++;
    end
    check("t6_completed", acc_pkts, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check("t6_stays_idle", valid, 0);
    end
    check("t6_drained", exp_q.size(), 0);
    check("t6_pkt_count", pkt_count, 1);

    // 6b: reset while beat 2 of the next packet is on the bus
    acc_data_q.delete();
    acc_ch_q.delete();
    model_packet(0, 4);
    enable = 1'b1;
    lim = 0;
    while (acc_data_q.size() < 2 && lim < 20) begin
      @(negedge clk);
      #1;
      lim++;
    end
    check("t6_two_beats", acc_data_q.size(), 2);
    @(posedge clk);
    #1;
    check("t6_beat2_shown", data, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_valid", valid, 0);
    check("t6_rst_data", data, 0);
    check("t6_rst_channel", channel, 0);
    check("t6_rst_sop", sop, 0);
    check("t6_rst_eop", eop, 0);
    check("t6_rst_pkt_count", pkt_count, 0);
    rst = 1'b0;
    model_reset();
    acc_data_q.delete();
    acc_ch_q.delete();
    model_packet(0, 4);
    run_test(1, 1, 50);
    check("t6_restart_ch", acc_ch_q[0], 0);
    check("t6_restart_data", acc_data_q[0], 0);
    check("t6_restart_count", pkt_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_source_avst.md
Name: pattern_source_avst

Overview:
Parametrised Avalon-ST test-pattern source for FPGA bench and bring-up use. It generates framed packets with startofpacket/endofpacket across multiple channels, selected round-robin. It supports continuous streaming under backpressure and several selectable data patterns. It sits in place of a live data source, upstream of any AVST sink (FIFO, DMA, checker).

Parameters:
DATA_WIDTH, 32, width of data bus (>= 8)
NUM_CHANNELS, 4, number of logical channels (>= 1); CH_W = max(1, $clog2(NUM_CHANNELS)) derived
LEN_WIDTH, 16, width of packet-length input

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = generate packets; 0 = stop after current packet
mode  in  2  pattern select: 0 counter, 1 walking-one, 2 tagged, 3 = counter
pkt_len  in  LEN_WIDTH  beats per packet; 0 treated as 1
idle_gap  in  8  cycles with valid low between packets
ready  in  1  sink ready (readyLatency 0)
valid  out  1  beat valid
data  out  DATA_WIDTH  beat payload
channel  out  CH_W  channel of current packet
startofpacket  out  1  first beat of packet
endofpacket  out  1  last beat of packet
pkt_count  out  32  completed packets since reset, wraps at 2^32

Behaviour:
- Reset (rst=1 at posedge): state IDLE; valid, data, channel, startofpacket, endofpacket, pkt_count all 0; per-channel counters 0; next channel 0. Reset mid-packet abandons the packet, with no eop issued.
- All outputs are registered.
- A beat is accepted on a cycle with valid && ready.
- While valid && !ready, data, channel, sop and eop are held stable.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - valid = 0.
  - If enable = 1, latch mode, pkt_len (0 -> 1), idle_gap and current channel; go to SEND.
  - valid = 1 with the first beat on the next cycle (1-cycle latency from enable sampled high).
- SEND:
  - beat index b runs 0..L-1.
  - sop = (b == 0); eop = (b == L-1); L = 1 gives sop = eop = 1 on a single beat.
  - On accept of a non-last beat: b increments and the next beat is presented the following cycle. Back-to-back accepts are allowed (throughput 1 beat/cycle).
  - On accept of the last beat:
    - pkt_count++.
    - Channel advances round-robin (NUM_CHANNELS-1 wraps to 0).
    - If latched gap > 0, go to GAP.
    - Else if enable = 1, latch new params and present sop of the next packet in the very next cycle.
    - Else go to IDLE with valid = 0 next cycle.
- GAP:
  - valid = 0 for exactly idle_gap cycles.
  - Then, if enable = 1, behave as IDLE-with-enable (latch params, valid next cycle); otherwise go to IDLE.
- Deasserting enable mid-packet does not truncate; the packet completes normally.
- Changes on mode, pkt_len and idle_gap mid-packet are ignored until the next latch point.
- Patterns (b = beat index within packet, c = channel):
  - mode 0: per-channel DATA_WIDTH counter value. That channel's counter increments by 1 on each accepted beat, wraps 2^DATA_WIDTH-1 -> 0, and persists across packets.
  - mode 1: 1 << (b mod DATA_WIDTH).
  - mode 2: c in bits [DATA_WIDTH-1 -: 8] (zero-extended/truncated to 8); b mod 2^(DATA_WIDTH-8) in low bits.
  - mode 3: identical to mode 0.
- When NUM_CHANNELS = 1, channel is always 0.

Test Plan:
1. rst, then enable=1, mode=0, pkt_len=4, idle_gap=0, ready=1 constantly. Required response:
   - valid rises 1 cycle after enable.
   - Packets ch0: data 0,1,2,3; ch1: 0,1,2,3; ch2 …; then ch0 resumes at 4,5,6,7.
   - sop on beats 0, eop on beats 3, no valid gaps.
   - pkt_count = 5 after 20 beats.
2. Backpressure: pkt_len=3, ready toggles 1,0,0,1,0,1. Required response:
   - data/sop/eop stable while ready = 0.
   - Exactly 3 beats accepted per packet, with values 0,1,2 uncorrupted.
3. Single-beat and zero length: pkt_len=0, then 1 → every beat has sop = eop = 1; channel sequence 0,1,2,3,0; pkt_count increments per beat.
4. idle_gap=3, pkt_len=2, ready=1 → after each eop accept, valid = 0 for exactly 3 cycles, then sop of the next packet.
5. Pattern modes: pkt_len=34, mode=1, DATA_WIDTH=32 → data 0x1, 0x2, …, 0x80000000, then 0x1, 0x2. Mode 2 on ch3, beat 5 → data 0x03000005.
6. Control edge cases:
   - enable dropped at beat 1 of a 4-beat packet: beats 2 and 3 still delivered with eop, then valid = 0 permanently.
   - rst at beat 2 of a later packet: all outputs 0 next cycle; after release with enable = 1, the restart is on ch0 with counter data 0.
